// File: rtl/i2c_pkg.sv
// Shared types and constants for the TMP100 I2C responder.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRack
  } state_e;

  localparam logic [1:0]  PTR_TEMP           = 2'd0;
  localparam logic [1:0]  PTR_CFG            = 2'd1;
  localparam logic [1:0]  PTR_TLOW           = 2'd2;
  localparam logic [1:0]  PTR_THIGH          = 2'd3;

  localparam logic [15:0] TLOW_RST           = 16'h4B00;
  localparam logic [15:0] THIGH_RST          = 16'h5000;

  localparam logic [6:0]  DEFAULT_SLAVE_ADDR = 7'h48;

endpackage

// File: rtl/i2c_tmp100_slave_if.sv
// Open-drain I2C bus as seen by one master and one responder.
interface i2c_tmp100_slave_if;
  logic i2c_scl_in;
  logic i2c_sda_in;
  logic i2c_sda_oe;

  modport master (output i2c_scl_in, output i2c_sda_in, input i2c_sda_oe);
  modport slave  (input i2c_scl_in, input i2c_sda_in, output i2c_sda_oe);
endinterface

// File: rtl/i2c_bus_cond.sv
// SCL/SDA synchronizer with SCL edge and START/STOP condition detection.
module i2c_bus_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i2c_clk_in,
  input  logic i2c_rst_in,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s;

  // Synchronizer chains plus one history stage; reset to idle-high bus.
  always_ff @(posedge i2c_clk_in) begin
    if (i2c_rst_in) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda   = sda_sync_q[SYNC_STAGES-1];

  // SDA moving while SCL stays high is a bus condition, never a data bit.
  always_comb begin
    scl_rise  = scl_s & ~scl_prev_q;
    scl_fall  = ~scl_s & scl_prev_q;
    start_det = scl_s & scl_prev_q & sda_prev_q & ~sda;
    stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda;
  end

endmodule

// File: rtl/i2c_tmp100_slave.sv
// TMP100-compatible I2C responder: pointer register, config register and a
// temperature word read back through a coherent snapshot.
// Optional macro I2C_TMP100_SLAVE_TLIMIT_EN adds TLOW/THIGH and alert_out.
module i2c_tmp100_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     i2c_clk_in,
  input  logic                     i2c_rst_in,
  i2c_tmp100_slave_if.slave        bus,
  input  logic [15:0]              temp_in,
  output logic [7:0]               cfg_out,
  output logic                     cfg_wr,
  output logic                     busy
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
  ,
  output logic                     alert_out
`endif
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_cond #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_cond (
    .i2c_clk_in (i2c_clk_in),
    .i2c_rst_in (i2c_rst_in),
    .scl_in     (bus.i2c_scl_in),
    .sda_in     (bus.i2c_sda_in),
    .sda        (sda),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  // Second half of an ACK slot: ACK already driven (write) or released (read).
  logic        phase_q, phase_d;
  logic        rw_q, rw_d;
  logic [1:0]  ptr_q, ptr_d;
  // Byte index within a register: 0 = MSB, 1 = LSB.
  logic        idx_q, idx_d;
  logic [15:0] snap_q, snap_d;
  logic [7:0]  cfg_q, cfg_d;
  logic        cfg_wr_q, cfg_wr_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
  logic [15:0] tlow_q, tlow_d;
  logic [15:0] thigh_q, thigh_d;
  logic        alert_q;
`endif

  logic [7:0] byte_in;
  logic [7:0] ld_byte;
  assign byte_in = {shift_q[6:0], sda};

  function automatic logic [7:0] sel_byte(input logic [1:0] ptr, input logic idx,
                                          input logic [15:0] snap);
    logic [7:0] b;
    b = 8'h00;
    unique case (ptr)
      PTR_TEMP:  b = idx ? snap[7:0] : snap[15:8];
      PTR_CFG:   b = cfg_q;
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
      PTR_TLOW:  b = idx ? tlow_q[7:0] : tlow_q[15:8];
      PTR_THIGH: b = idx ? thigh_q[7:0] : thigh_q[15:8];
`else
      PTR_TLOW, PTR_THIGH: b = 8'h00;
`endif
    endcase
    return b;
  endfunction

  // Protocol FSM next-state; SDA drive only changes on detected SCL falls.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    cfg_d     = cfg_q;
    cfg_wr_d  = 1'b0;
    oe_d      = oe_q;
    busy_d    = busy_q;
    ld_byte   = 8'h00;
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
    tlow_d    = tlow_q;
    thigh_d   = thigh_q;
`endif
    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      oe_d      = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b0;
              if (state_q == StAddr) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  rw_d    = byte_in[0];
                  state_d = StAddrAck;
                end else begin
                  state_d = StIdle;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = byte_in[1:0];
                idx_d   = 1'b0;
                state_d = StPtrAck;
              end else begin
                state_d = StWdataAck;
                idx_d   = ~idx_q;
                if (ptr_q == PTR_CFG) begin
                  cfg_d    = byte_in;
                  cfg_wr_d = 1'b1;
                end
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
                if (ptr_q == PTR_TLOW) begin
                  if (idx_q) tlow_d[7:0] = byte_in;
                  else       tlow_d[15:8] = byte_in;
                end
                if (ptr_q == PTR_THIGH) begin
                  if (idx_q) thigh_d[7:0] = byte_in;
                  else       thigh_d[15:8] = byte_in;
                end
`endif
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d    = 1'b1;
              phase_d = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == StAddrAck && rw_q) begin
                // First read byte comes straight from temp_in as it is captured.
                snap_d  = temp_in;
                idx_d   = 1'b0;
                ld_byte = sel_byte(ptr_q, 1'b0, temp_in);
                tx_d    = ld_byte;
                oe_d    = ~ld_byte[7];
                state_d = StRdata;
              end else begin
                oe_d    = 1'b0;
                state_d = (state_q == StAddrAck) ? StPtr : StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = StRack;
              phase_d = 1'b0;
            end
          end else if (scl_fall) begin
            tx_d = {tx_q[6:0], 1'b0};
            oe_d = ~tx_q[6];
          end
        end
        StRack: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d    = 1'b0;
              phase_d = 1'b1;
            end else begin
              // Only reached after the master ACKed; NACK leaves on the rise.
              idx_d     = ~idx_q;
              ld_byte   = sel_byte(ptr_q, ~idx_q, snap_q);
              tx_d      = ld_byte;
              oe_d      = ~ld_byte[7];
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = StRdata;
            end
          end else if (scl_rise && phase_q && sda) begin
            phase_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge i2c_clk_in) begin
    if (i2c_rst_in) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 8'h00;
      phase_q   <= 1'b0;
      rw_q      <= 1'b0;
      ptr_q     <= PTR_TEMP;
      idx_q     <= 1'b0;
      snap_q    <= 16'h0000;
      cfg_q     <= 8'h00;
      cfg_wr_q  <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
      tlow_q    <= TLOW_RST;
      thigh_q   <= THIGH_RST;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      cfg_q     <= cfg_d;
      cfg_wr_q  <= cfg_wr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
      tlow_q    <= tlow_d;
      thigh_q   <= thigh_d;
`endif
    end
  end

`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
  // Comparator-mode alert with hysteresis between TLOW and THIGH.
  always_ff @(posedge i2c_clk_in) begin
    if (i2c_rst_in) begin
      alert_q <= 1'b0;
    end else if ($signed(temp_in[15:4]) >= $signed(thigh_q[15:4])) begin
      alert_q <= 1'b1;
    end else if ($signed(temp_in[15:4]) < $signed(tlow_q[15:4])) begin
      alert_q <= 1'b0;
    end
  end

  assign alert_out = alert_q ^ cfg_q[2];
`endif

  assign bus.i2c_sda_oe = oe_q;
  assign cfg_out        = cfg_q;
  assign cfg_wr         = cfg_wr_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_i2c_tmp100_slave.sv
// Directed bench for i2c_tmp100_slave: bit-banged I2C master on an
// open-drain bus, hand-computed expected bytes and ACKs.
module tb_i2c_tmp100_slave;

  localparam int Q = 8;  // system clocks per quarter SCL period

  logic        clk;
  logic        rst;
  logic [15:0] temp;
  logic [7:0]  cfg_out;
  logic        cfg_wr;
  logic        busy;
  logic        m_sda;
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
  logic        alert;
`endif

  int tests;
  int fails;
  int cfg_wr_cnt;

  i2c_tmp100_slave_if bus ();

  // Wired-AND of master release level and responder pull-down.
  assign bus.i2c_sda_in = m_sda & ~bus.i2c_sda_oe;

  i2c_tmp100_slave dut (
    .i2c_clk_in (clk),
    .i2c_rst_in (rst),
    .bus        (bus),
    .temp_in    (temp),
    .cfg_out    (cfg_out),
    .cfg_wr     (cfg_wr),
    .busy       (busy)
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
    ,
    .alert_out  (alert)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (cfg_wr) cfg_wr_cnt <= cfg_wr_cnt + 1;

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    bus.i2c_scl_in = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    bus.i2c_scl_in = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    bus.i2c_scl_in = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    m_sda = b; wait_q();
    bus.i2c_scl_in = 1'b1; wait_q();
    seen = bus.i2c_sda_in; wait_q();
    bus.i2c_scl_in = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] data, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(data[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] data);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      data[i] = s;
    end
    clock_bit(nack, s);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic a0, a1;
    i2c_start();
    send_byte(8'h90, a0);
    send_byte(p, a1);
    i2c_stop();
    tests++;
    if ({a0, a1} !== 2'b00) begin
      $display("FAIL set_ptr acks: got %b want 00", {a0, a1}); fails++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.i2c_sda_oe !== 1'b0) begin
      $display("FAIL reset sda_oe: got %b want 0", bus.i2c_sda_oe); fails++;
    end
    tests++;
    if (cfg_out !== 8'h00) begin
      $display("FAIL reset cfg_out: got %h want 00", cfg_out); fails++;
    end
    tests++;
    if (cfg_wr !== 1'b0) begin
      $display("FAIL reset cfg_wr: got %b want 0", cfg_wr); fails++;
    end
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL reset busy: got %b want 0", busy); fails++;
    end
  endtask

  task automatic test_cfg_write();
    logic a0, a1, a2;
    int   c0;
    c0 = cfg_wr_cnt;
    i2c_start();
    tests++;
    if (busy !== 1'b1) begin
      $display("FAIL cfg busy during: got %b want 1", busy); fails++;
    end
    send_byte(8'h90, a0);
    send_byte(8'h01, a1);
    send_byte(8'h60, a2);
    i2c_stop();
    wait_q();
    tests++;
    if ({a0, a1, a2} !== 3'b000) begin
      $display("FAIL cfg acks: got %b want 000", {a0, a1, a2}); fails++;
    end
    tests++;
    if (cfg_out !== 8'h60) begin
      $display("FAIL cfg value: got %h want 60", cfg_out); fails++;
    end
    tests++;
    if (cfg_wr_cnt - c0 !== 1) begin
      $display("FAIL cfg_wr pulses: got %0d want 1", cfg_wr_cnt - c0); fails++;
    end
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL cfg busy after stop: got %b want 0", busy); fails++;
    end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start();
    send_byte(8'h90, a0);
    send_byte(8'h01, a1);
    i2c_start();
    send_byte(8'h91, a2);
    recv_byte(1'b1, d);
    i2c_stop();
    tests++;
    if ({a0, a1, a2} !== 3'b000) begin
      $display("FAIL rstart acks: got %b want 000", {a0, a1, a2}); fails++;
    end
    tests++;
    if (d !== 8'h60) begin
      $display("FAIL rstart cfg read: got %h want 60", d); fails++;
    end
  endtask

  task automatic test_temp_read();
    logic a0;
    logic [7:0] d0, d1;
    set_ptr(8'h00);
    temp = 16'h1920;
    i2c_start();
    send_byte(8'h91, a0);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    tests++;
    if (bus.i2c_sda_oe !== 1'b0) begin
      $display("FAIL temp released after nack: got %b want 0", bus.i2c_sda_oe); fails++;
    end
    i2c_stop();
    tests++;
    if (a0 !== 1'b0) begin
      $display("FAIL temp addr ack: got %b want 0", a0); fails++;
    end
    tests++;
    if ({d0, d1} !== 16'h1920) begin
      $display("FAIL temp bytes: got %h want 1920", {d0, d1}); fails++;
    end
  endtask

  task automatic test_snapshot();
    logic a0, a1;
    logic [7:0] d0, d1, d2;
    temp = 16'h1920;
    i2c_start();
    send_byte(8'h91, a0);
    recv_byte(1'b0, d0);
    temp = 16'hAB70;
    recv_byte(1'b1, d1);
    i2c_stop();
    tests++;
    if ({d0, d1} !== 16'h1920) begin
      $display("FAIL snapshot bytes: got %h want 1920", {d0, d1}); fails++;
    end
    i2c_start();
    send_byte(8'h91, a1);
    recv_byte(1'b1, d2);
    i2c_stop();
    tests++;
    if (d2 !== 8'hAB) begin
      $display("FAIL snapshot refresh: got %h want ab", d2); fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic a0;
    logic [7:0] d0, d1, d2;
    temp = 16'h1230;
    i2c_start();
    send_byte(8'h91, a0);
    recv_byte(1'b0, d0);
    recv_byte(1'b0, d1);
    recv_byte(1'b1, d2);
    i2c_stop();
    tests++;
    if ({d0, d1, d2} !== 24'h123012) begin
      $display("FAIL b2b bytes: got %h want 123012", {d0, d1, d2}); fails++;
    end
  endtask

  task automatic test_bad_addr();
    logic a0, a1;
    i2c_start();
    send_byte(8'h92, a0);
    send_byte(8'h90, a1);
    tests++;
    if (a0 !== 1'b1) begin
      $display("FAIL bad addr ack: got %b want 1", a0); fails++;
    end
    tests++;
    if (a1 !== 1'b1) begin
      $display("FAIL bad addr stays idle: got %b want 1", a1); fails++;
    end
    tests++;
    if (busy !== 1'b1) begin
      $display("FAIL bad addr busy: got %b want 1", busy); fails++;
    end
    i2c_stop();
  endtask

  task automatic test_ptr2();
    logic a0, a1, a2, a3, a4;
    logic [7:0] d0, d1;
    logic [15:0] want;
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
    want = 16'h4A80;
`else
    want = 16'h0000;
`endif
    i2c_start();
    send_byte(8'h90, a0);
    send_byte(8'h02, a1);
    send_byte(8'h4A, a2);
    send_byte(8'h80, a3);
    i2c_stop();
    i2c_start();
    send_byte(8'h91, a4);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    i2c_stop();
    tests++;
    if ({a0, a1, a2, a3, a4} !== 5'b00000) begin
      $display("FAIL ptr2 acks: got %b want 00000", {a0, a1, a2, a3, a4}); fails++;
    end
    tests++;
    if ({d0, d1} !== want) begin
      $display("FAIL ptr2 read: got %h want %h", {d0, d1}, want); fails++;
    end
    tests++;
    if (cfg_out !== 8'h60) begin
      $display("FAIL ptr2 cfg untouched: got %h want 60", cfg_out); fails++;
    end
  endtask

  task automatic test_reset_mid();
    logic a0, a1;
    logic [7:0] d;
    set_ptr(8'h01);
    i2c_start();
    send_byte(8'h91, a0);
    // cfg 8'h60 has MSB 0, so the responder is pulling SDA low now.
    tests++;
    if (bus.i2c_sda_oe !== 1'b1) begin
      $display("FAIL midreset drive before: got %b want 1", bus.i2c_sda_oe); fails++;
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.i2c_sda_oe !== 1'b0) begin
      $display("FAIL midreset release: got %b want 0", bus.i2c_sda_oe); fails++;
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, cfg_out} !== 9'h000) begin
      $display("FAIL midreset state: got busy %b cfg %h want 0 00", busy, cfg_out); fails++;
    end
    i2c_stop();
    temp = 16'h7FF0;
    i2c_start();
    send_byte(8'h91, a1);
    recv_byte(1'b1, d);
    i2c_stop();
    tests++;
    if (d !== 8'h7F) begin
      $display("FAIL midreset ptr reset: got %h want 7f", d); fails++;
    end
  endtask

`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
  task automatic test_alert();
    temp = 16'h5000;
    repeat (4) @(negedge clk);
    tests++;
    if (alert !== 1'b1) begin
      $display("FAIL alert set: got %b want 1", alert); fails++;
    end
    temp = 16'h4C00;
    repeat (4) @(negedge clk);
    tests++;
    if (alert !== 1'b1) begin
      $display("FAIL alert hold: got %b want 1", alert); fails++;
    end
    temp = 16'h4A00;
    repeat (4) @(negedge clk);
    tests++;
    if (alert !== 1'b0) begin
      $display("FAIL alert clear: got %b want 0", alert); fails++;
    end
  endtask
`endif

  initial begin
    tests          = 0;
    fails          = 0;
    cfg_wr_cnt     = 0;
    rst            = 1'b1;
    temp           = 16'h0000;
    m_sda          = 1'b1;
    bus.i2c_scl_in = 1'b1;
    test_reset();
    test_cfg_write();
    test_repeated_start();
    test_temp_read();
    test_snapshot();
    test_back_to_back();
    test_bad_addr();
    test_ptr2();
`ifdef I2C_TMP100_SLAVE_TLIMIT_EN
    test_alert();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
